// File: rtl/rv_alu_decode.sv
`default_nettype none
// ============================================================================
// Module      : rv_alu_decode
// Description : RV32I ALU-control decoder with a single-entry registered
//               valid/ready output stage (OP, OP-IMM, LOAD, STORE, LUI).
// Revision    : 1.0 - initial release
// ============================================================================
module rv_alu_decode (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] instr_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic        flush_i,
    input  logic        out_ready_i,
    output logic        out_valid_o,
    output logic [3:0]  aluctrl_o,
    output logic        alusrc_o,
    output logic [31:0] imm_o,
    output logic [4:0]  rs1_o,
    output logic [4:0]  rs2_o,
    output logic [4:0]  rd_o,
    output logic        regwrite_o,
    output logic        illegal_o
);

    // ALU operation codes
    localparam logic [3:0] C_ALU_SUB  = 4'b0000;
    localparam logic [3:0] C_ALU_ADD  = 4'b0001;
    localparam logic [3:0] C_ALU_SLL  = 4'b0010;
    localparam logic [3:0] C_ALU_SLT  = 4'b0011;
    localparam logic [3:0] C_ALU_SLTU = 4'b0100;
    localparam logic [3:0] C_ALU_XOR  = 4'b0101;
    localparam logic [3:0] C_ALU_SRA  = 4'b0110;
    localparam logic [3:0] C_ALU_SRL  = 4'b0111;
    localparam logic [3:0] C_ALU_OR   = 4'b1000;
    localparam logic [3:0] C_ALU_AND  = 4'b1001;

    // Major opcodes
    localparam logic [6:0] C_OPC_OP     = 7'b0110011;
    localparam logic [6:0] C_OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] C_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] C_OPC_STORE  = 7'b0100011;
    localparam logic [6:0] C_OPC_LUI    = 7'b0110111;

    localparam logic [6:0] C_F7_BASE = 7'b0000000;
    localparam logic [6:0] C_F7_ALT  = 7'b0100000;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        bad;
    logic [3:0]  alu_raw;
    logic        alusrc_raw;
    logic        regwrite_raw;
    logic [31:0] imm_raw;

    logic [3:0]  aluctrl_d,  aluctrl_q;
    logic        alusrc_d,   alusrc_q;
    logic [31:0] imm_d,      imm_q;
    logic [4:0]  rs1_d,      rs1_q;
    logic [4:0]  rs2_d,      rs2_q;
    logic [4:0]  rd_d,       rd_q;
    logic        regwrite_d, regwrite_q;
    logic        illegal_d,  illegal_q;
    logic        out_valid_q;
    logic        accept;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];

    // Combinational decode of the incoming instruction word
    always_comb begin
        bad          = 1'b0;
        alu_raw      = C_ALU_ADD;
        alusrc_raw   = 1'b0;
        regwrite_raw = 1'b0;
        imm_raw      = 32'd0;
        rs1_d        = instr_i[19:15];
        rs2_d        = instr_i[24:20];
        rd_d         = instr_i[11:7];

        case (opcode)
            C_OPC_OP, C_OPC_OPIMM: begin
                regwrite_raw = 1'b1;
                if (opcode == C_OPC_OPIMM) begin
                    alusrc_raw = 1'b1;
                    imm_raw    = {{20{instr_i[31]}}, instr_i[31:20]};
                end
                case (funct3)
                    3'b000: begin
                        // OP-IMM has no subtract; its upper bits are immediate
                        if (opcode == C_OPC_OPIMM || funct7 == C_F7_BASE)
                            alu_raw = C_ALU_ADD;
                        else if (funct7 == C_F7_ALT)
                            alu_raw = C_ALU_SUB;
                        else
                            bad = 1'b1;
                    end
                    3'b001: begin
                        alu_raw = C_ALU_SLL;
                        bad     = (funct7 != C_F7_BASE);
                    end
                    3'b101: begin
                        if (funct7 == C_F7_BASE)
                            alu_raw = C_ALU_SRL;
                        else if (funct7 == C_F7_ALT)
                            alu_raw = C_ALU_SRA;
                        else
                            bad = 1'b1;
                    end
                    default: begin
                        case (funct3)
                            3'b010:  alu_raw = C_ALU_SLT;
                            3'b011:  alu_raw = C_ALU_SLTU;
                            3'b100:  alu_raw = C_ALU_XOR;
                            3'b110:  alu_raw = C_ALU_OR;
                            default: alu_raw = C_ALU_AND;
                        endcase
                        // Register form requires a zero funct7 for these ops
                        bad = (opcode == C_OPC_OP) && (funct7 != C_F7_BASE);
                    end
                endcase
            end
            C_OPC_LOAD: begin
                alusrc_raw   = 1'b1;
                regwrite_raw = 1'b1;
                imm_raw      = {{20{instr_i[31]}}, instr_i[31:20]};
            end
            C_OPC_STORE: begin
                alusrc_raw = 1'b1;
                imm_raw    = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            end
            C_OPC_LUI: begin
                alusrc_raw   = 1'b1;
                regwrite_raw = 1'b1;
                rs1_d        = 5'd0;
                imm_raw      = {instr_i[31:12], 12'd0};
            end
            default: bad = 1'b1;
        endcase

        // Unsupported encodings collapse to a harmless, non-writing add
        illegal_d  = bad;
        aluctrl_d  = bad ? C_ALU_ADD : alu_raw;
        alusrc_d   = bad ? 1'b0 : alusrc_raw;
        regwrite_d = bad ? 1'b0 : regwrite_raw;
        imm_d      = bad ? 32'd0 : imm_raw;
    end

    assign in_ready_o = (!out_valid_q || out_ready_i) && !flush_i;
    assign accept     = in_valid_i && in_ready_o;

    // Output stage: reset beats flush, flush beats accept, accept beats drain
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
            aluctrl_q   <= C_ALU_ADD;
            alusrc_q    <= 1'b0;
            imm_q       <= 32'd0;
            rs1_q       <= 5'd0;
            rs2_q       <= 5'd0;
            rd_q        <= 5'd0;
            regwrite_q  <= 1'b0;
            illegal_q   <= 1'b0;
        end else if (flush_i) begin
            out_valid_q <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            aluctrl_q   <= aluctrl_d;
            alusrc_q    <= alusrc_d;
            imm_q       <= imm_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
            regwrite_q  <= regwrite_d;
            illegal_q   <= illegal_d;
        end else if (out_ready_i) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid_o = out_valid_q;
    assign aluctrl_o   = aluctrl_q;
    assign alusrc_o    = alusrc_q;
    assign imm_o       = imm_q;
    assign rs1_o       = rs1_q;
    assign rs2_o       = rs2_q;
    assign rd_o        = rd_q;
    assign regwrite_o  = regwrite_q;
    assign illegal_o   = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_rv_alu_decode.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv_alu_decode
// Description : Directed bench for rv_alu_decode: decode table plus stall,
//               streaming/flush and reset-during-stall sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv_alu_decode;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] instr_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic        flush_i;
    logic        out_ready_i;
    logic        out_valid_o;
    logic [3:0]  aluctrl_o;
    logic        alusrc_o;
    logic [31:0] imm_o;
    logic [4:0]  rs1_o;
    logic [4:0]  rs2_o;
    logic [4:0]  rd_o;
    logic        regwrite_o;
    logic        illegal_o;

    int total = 0;
    int bad   = 0;

    rv_alu_decode u_dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .instr_i     (instr_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .flush_i     (flush_i),
        .out_ready_i (out_ready_i),
        .out_valid_o (out_valid_o),
        .aluctrl_o   (aluctrl_o),
        .alusrc_o    (alusrc_o),
        .imm_o       (imm_o),
        .rs1_o       (rs1_o),
        .rs2_o       (rs2_o),
        .rd_o        (rd_o),
        .regwrite_o  (regwrite_o),
        .illegal_o   (illegal_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] instr;
        logic [3:0]  alu;
        logic        src;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rw;
        logic        ill;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_out(input string tag, input vec_t v);
        check({tag, " valid"},    {31'd0, out_valid_o}, 32'd1);
        check({tag, " aluctrl"},  {28'd0, aluctrl_o},   {28'd0, v.alu});
        check({tag, " alusrc"},   {31'd0, alusrc_o},    {31'd0, v.src});
        check({tag, " imm"},      imm_o,                v.imm);
        check({tag, " rs1"},      {27'd0, rs1_o},       {27'd0, v.rs1});
        check({tag, " rs2"},      {27'd0, rs2_o},       {27'd0, v.rs2});
        check({tag, " rd"},       {27'd0, rd_o},        {27'd0, v.rd});
        check({tag, " regwrite"}, {31'd0, regwrite_o},  {31'd0, v.rw});
        check({tag, " illegal"},  {31'd0, illegal_o},   {31'd0, v.ill});
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " valid"},    {31'd0, out_valid_o}, 32'd0);
        check({tag, " aluctrl"},  {28'd0, aluctrl_o},   32'd1);
        check({tag, " alusrc"},   {31'd0, alusrc_o},    32'd0);
        check({tag, " imm"},      imm_o,                32'd0);
        check({tag, " rs1"},      {27'd0, rs1_o},       32'd0);
        check({tag, " rs2"},      {27'd0, rs2_o},       32'd0);
        check({tag, " rd"},       {27'd0, rd_o},        32'd0);
        check({tag, " regwrite"}, {31'd0, regwrite_o},  32'd0);
        check({tag, " illegal"},  {31'd0, illegal_o},   32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //              instr          alu    src  imm           rs1 rs2 rd  rw ill
        vecs[0]  = '{32'h40B50533, 4'h0, 1'b0, 32'h00000000, 10, 11, 10, 1'b1, 1'b0}; // sub
        vecs[1]  = '{32'hFFF50513, 4'h1, 1'b1, 32'hFFFFFFFF, 10, 31, 10, 1'b1, 1'b0}; // addi -1
        vecs[2]  = '{32'h40355513, 4'h6, 1'b1, 32'h00000403, 10,  3, 10, 1'b1, 1'b0}; // srai
        vecs[3]  = '{32'h02B50533, 4'h1, 1'b0, 32'h00000000, 10, 11, 10, 1'b0, 1'b1}; // mul
        vecs[4]  = '{32'h00A5A223, 4'h1, 1'b1, 32'h00000004, 11, 10,  4, 1'b0, 1'b0}; // sw
        vecs[5]  = '{32'h123452B7, 4'h1, 1'b1, 32'h12345000,  0,  3,  5, 1'b1, 1'b0}; // lui
        vecs[6]  = '{32'h80052283, 4'h1, 1'b1, 32'hFFFFF800, 10,  0,  5, 1'b1, 1'b0}; // lw -2048
        vecs[7]  = '{32'h02051513, 4'h1, 1'b0, 32'h00000000, 10,  0, 10, 1'b0, 1'b1}; // slli bad f7
        vecs[8]  = '{32'h0000007F, 4'h1, 1'b0, 32'h00000000,  0,  0,  0, 1'b0, 1'b1}; // bad opcode
        vecs[9]  = '{32'h00D675B3, 4'h9, 1'b0, 32'h00000000, 12, 13, 11, 1'b1, 1'b0}; // and
        vecs[10] = '{32'h003130B3, 4'h4, 1'b0, 32'h00000000,  2,  3,  1, 1'b1, 1'b0}; // sltu
        vecs[11] = '{32'h7FF34293, 4'h5, 1'b1, 32'h000007FF,  6, 31,  5, 1'b1, 1'b0}; // xori
        // or with funct7=0100000 is not a valid encoding
        // (kept out of the table; exercised in the streaming sequence)

        rst_i       = 1'b1;
        instr_i     = 32'd0;
        in_valid_i  = 1'b0;
        flush_i     = 1'b0;
        out_ready_i = 1'b0;
        tick();
        tick();
        check_reset_state("reset");
        rst_i = 1'b0;
        #1;
        check("ready after reset", {31'd0, in_ready_o}, 32'd1);

        // Decode table, streamed back to back
        out_ready_i = 1'b1;
        for (int i = 0; i < 12; i++) begin
            instr_i    = vecs[i].instr;
            in_valid_i = 1'b1;
            tick();
            check_out($sformatf("vec%0d", i), vecs[i]);
        end
        in_valid_i = 1'b0;
        tick();
        check("drain valid", {31'd0, out_valid_o}, 32'd0);

        // Stall: hold sub at output for 5 cycles while addi waits
        out_ready_i = 1'b0;
        instr_i     = vecs[0].instr;
        in_valid_i  = 1'b1;
        tick();
        check_out("stall first", vecs[0]);
        instr_i = vecs[1].instr;
        for (int c = 0; c < 5; c++) begin
            check("stall in_ready", {31'd0, in_ready_o}, 32'd0);
            tick();
            check_out($sformatf("stall hold%0d", c), vecs[0]);
        end
        out_ready_i = 1'b1;
        #1;
        check("release in_ready", {31'd0, in_ready_o}, 32'd1);
        tick();
        check_out("release next", vecs[1]);
        in_valid_i = 1'b0;
        tick();
        check("release no dup", {31'd0, out_valid_o}, 32'd0);

        // Stream 4; flush while the 3rd is held
        instr_i    = vecs[9].instr;  in_valid_i = 1'b1; tick(); check_out("s0", vecs[9]);
        instr_i    = vecs[10].instr; tick(); check_out("s1", vecs[10]);
        instr_i    = vecs[11].instr; tick(); check_out("s2", vecs[11]);
        instr_i    = 32'h40D666B3;   // illegal "or" with alternate funct7
        flush_i    = 1'b1;
        #1;
        check("flush in_ready", {31'd0, in_ready_o}, 32'd0);
        tick();
        check("flush valid", {31'd0, out_valid_o}, 32'd0);
        check("flush payload kept", {28'd0, aluctrl_o}, 32'd5);
        check("flush no accept ill", {31'd0, illegal_o}, 32'd0);
        flush_i    = 1'b0;
        in_valid_i = 1'b0;
        tick();
        check("post flush valid", {31'd0, out_valid_o}, 32'd0);
        instr_i    = 32'h40D666B3;
        in_valid_i = 1'b1;
        tick();
        check_out("or alt f7", '{32'h40D666B3, 4'h1, 1'b0, 32'h0, 12, 13, 13, 1'b0, 1'b1});
        in_valid_i = 1'b0;
        tick();

        // Reset while stalled with a valid lui held; reset wins over flush
        out_ready_i = 1'b0;
        instr_i     = vecs[5].instr;
        in_valid_i  = 1'b1;
        tick();
        check_out("pre reset", vecs[5]);
        instr_i = vecs[1].instr;
        rst_i   = 1'b1;
        flush_i = 1'b1;
        tick();
        check_reset_state("mid-stall reset");
        rst_i      = 1'b0;
        flush_i    = 1'b0;
        in_valid_i = 1'b0;
        #1;
        check("ready after 2nd reset", {31'd0, in_ready_o}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
